// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM states and request record for the data-memory frontend
package dmem_pkg;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, ERR_RSP} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic [2:0]  fn3;
  } req_t;
  function automatic logic [2:0] nbytes(input logic [2:0] fn3);
    return fn3[1:0] == 2'b00 ? 3'd1 : fn3[1:0] == 2'b01 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/dmem_req_fifo.sv
// dmem_req_fifo: synchronous request queue with registered full/empty flags
module dmem_req_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic mem_clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_n;
  logic do_push, do_pop;
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign cnt_n   = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rdata   = mem[rp];
  always_ff @(posedge mem_clk)
    if (do_push) mem[wp] <= wdata;
  always_ff @(posedge mem_clk or negedge resetn)
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt   <= cnt_n;
      full  <= cnt_n == (AW+1)'(DEPTH);
      empty <= cnt_n == '0;
    end
endmodule

// File: rtl/dmem_req_frontend.sv
// dmem_req_frontend: queues CPU loads/stores, range-checks them and drives a byte-serial RAM backend
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of forwarding them.
module dmem_req_frontend import dmem_pkg::*; #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_2000,
  parameter int          MEM_BYTES  = 32768,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        mem_clk,
  input  logic        resetn,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_wr_en,
  input  logic [2:0]  cpu_fn3,
  output logic        be_req_valid,
  input  logic        be_req_ready,
  output logic [14:0] be_addr,
  output logic [31:0] be_wdata,
  output logic        be_wr_en,
  output logic [2:0]  be_fn3,
  output logic [2:0]  be_nbytes,
  input  logic        be_rsp_valid,
  input  logic [31:0] be_rsp_data,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rsp_data,
  output logic        cpu_rsp_err,
  output logic        cpu_stall
);
  state_t state;
  req_t head;
  logic full, empty, pop;
  logic [31:0] offset;
  logic [2:0] nb;
  logic range_bad, fn_bad, mis_bad, illegal;
  assign cpu_req_ready = !full;
  assign pop = state == IDLE && !empty;
  dmem_req_fifo #(.DEPTH(FIFO_DEPTH), .T(req_t)) u_fifo (
    .mem_clk(mem_clk),
    .resetn (resetn),
    .push   (cpu_req_valid & cpu_req_ready),
    .pop    (pop),
    .wdata  ('{addr: cpu_addr, wdata: cpu_wdata, wr_en: cpu_wr_en, fn3: cpu_fn3}),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );
  assign offset = head.addr - BASE_ADDR;
  assign nb = nbytes(head.fn3);
  // 33-bit sum so an offset near 2^32 (address below BASE_ADDR) cannot wrap into range
  assign range_bad = ({1'b0, offset} + {30'b0, nb}) > 33'(MEM_BYTES);
  assign fn_bad = head.wr_en ? head.fn3 > SW : (head.fn3 == 3'b011 || head.fn3[2:1] == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_bad = (nb == 3'd2 && offset[0]) || (nb == 3'd4 && offset[1:0] != 2'b00);
`else
  assign mis_bad = 1'b0;
`endif
  assign illegal = range_bad | fn_bad | mis_bad;
  assign cpu_stall = !empty | (state != IDLE) | (cpu_req_valid & !cpu_req_ready);
  always_ff @(posedge mem_clk or negedge resetn)
    if (!resetn) begin
      state         <= IDLE;
      be_req_valid  <= 1'b0;
      be_addr       <= '0;
      be_wdata      <= '0;
      be_wr_en      <= 1'b0;
      be_fn3        <= '0;
      be_nbytes     <= '0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_err   <= 1'b0;
      cpu_rsp_data  <= '0;
    end else begin
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_err   <= 1'b0;
      cpu_rsp_data  <= '0;
      case (state)
        IDLE: if (!empty) begin
          if (illegal) begin
            state         <= ERR_RSP;
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_err   <= 1'b1;
          end else begin
            state        <= ISSUE;
            be_req_valid <= 1'b1;
            be_addr      <= offset[14:0];
            be_wdata     <= head.wdata;
            be_wr_en     <= head.wr_en;
            be_fn3       <= head.fn3;
            be_nbytes    <= nb;
          end
        end
        ISSUE: if (be_req_ready) begin
          be_req_valid <= 1'b0;
          state        <= WAIT_RSP;
        end
        WAIT_RSP: if (be_rsp_valid) begin
          state         <= IDLE;
          cpu_rsp_valid <= 1'b1;
          cpu_rsp_data  <= be_wr_en ? 32'h0 : be_rsp_data;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_req_frontend.sv
// tb_dmem_req_frontend: directed checks of queueing, range/funct3 faults, backpressure and reset
module tb_dmem_req_frontend;
  import dmem_pkg::*;
  logic mem_clk = 0, resetn = 0, cpu_req_valid = 0, cpu_wr_en = 0, be_req_ready = 1, be_rsp_valid;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, be_rsp_data;
  logic [2:0] cpu_fn3 = 0;
  logic cpu_req_ready, be_req_valid, be_wr_en, cpu_rsp_valid, cpu_rsp_err, cpu_stall;
  logic [14:0] be_addr;
  logic [31:0] be_wdata, cpu_rsp_data;
  logic [2:0] be_fn3, be_nbytes;
  int n_checks = 0, n_errors = 0, cyc = 0, lat = 1, bv_cycles = 0, rsp_cnt = 0, late_req = 0;
  bit be_auto = 1;
  logic [31:0] rsp_q[$], rd_q[$];
  logic re_q[$];
  int rc_q[$];
  logic [14:0] b_addr;
  logic [31:0] b_wdata;
  logic b_wr;
  logic [2:0] b_fn3, b_nb;

  dmem_req_frontend dut (
    .mem_clk(mem_clk), .resetn(resetn),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wr_en(cpu_wr_en), .cpu_fn3(cpu_fn3),
    .be_req_valid(be_req_valid), .be_req_ready(be_req_ready),
    .be_addr(be_addr), .be_wdata(be_wdata), .be_wr_en(be_wr_en), .be_fn3(be_fn3), .be_nbytes(be_nbytes),
    .be_rsp_valid(be_rsp_valid), .be_rsp_data(be_rsp_data),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data), .cpu_rsp_err(cpu_rsp_err),
    .cpu_stall(cpu_stall)
  );

  initial forever #5 mem_clk = ~mem_clk;
  initial forever begin @(posedge mem_clk); cyc++; end

  initial forever begin
    @(negedge mem_clk);
    if (be_req_valid) bv_cycles++;
    if (cpu_rsp_valid) begin
      rsp_cnt++;
      rd_q.push_back(cpu_rsp_data);
      re_q.push_back(cpu_rsp_err);
      rc_q.push_back(cyc);
    end
  end

  // backend model: answers each accepted request lat cycles after the handshake
  initial begin
    int late_seen = 0;
    logic [31:0] d;
    be_rsp_valid = 0;
    be_rsp_data = 0;
    forever begin
      @(negedge mem_clk);
      be_rsp_valid = 0;
      if (late_req != late_seen) begin
        late_seen = late_req;
        be_rsp_valid = 1;
        be_rsp_data = 32'hDEAD_BEEF;
      end else if (be_auto && be_req_valid && be_req_ready) begin
        b_addr = be_addr; b_wdata = be_wdata; b_wr = be_wr_en; b_fn3 = be_fn3; b_nb = be_nbytes;
        d = rsp_q.size() > 0 ? rsp_q.pop_front() : 32'h0;
        repeat (lat) @(negedge mem_clk);
        be_rsp_valid = 1;
        be_rsp_data = d;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] f, output int acc);
    int t = 0;
    cpu_addr = a; cpu_wdata = d; cpu_wr_en = w; cpu_fn3 = f; cpu_req_valid = 1;
    while (!cpu_req_ready && t < 100) begin @(negedge mem_clk); t++; end
    check("send_ready", cpu_req_ready, 1);
    acc = cyc;
    @(negedge mem_clk);
    cpu_req_valid = 0;
  endtask

  task automatic wait_rsp(input int n);
    int t = 0;
    while (rsp_cnt < n && t < 200) begin @(negedge mem_clk); t++; end
    check("rsp_count", rsp_cnt, n);
  endtask

  task automatic get_rsp(input string tag, input logic [31:0] d, input logic e, input int acc, input int l);
    check({tag, "_present"}, rd_q.size() > 0, 1);
    if (rd_q.size() > 0) begin
      check({tag, "_data"}, rd_q.pop_front(), d);
      check({tag, "_err"}, re_q.pop_front(), e);
      if (l > 0) check({tag, "_lat"}, rc_q.pop_front() - acc, l);
      else void'(rc_q.pop_front());
    end
  endtask

  initial begin
    int acc, a0, a1, a2, bv, t;
    repeat (3) @(negedge mem_clk);
    check("rst_ready", cpu_req_ready, 1);
    check("rst_be_valid", be_req_valid, 0);
    check("rst_rsp_valid", cpu_rsp_valid, 0);
    check("rst_rsp_err", cpu_rsp_err, 0);
    check("rst_rsp_data", cpu_rsp_data, 0);
    check("rst_be_addr", be_addr, 0);
    check("rst_be_nbytes", be_nbytes, 0);
    check("rst_stall", cpu_stall, 0);
    resetn = 1;
    @(negedge mem_clk);

    lat = 4; rsp_q.push_back(32'h1234_5678);
    send(32'h8000_2010, 32'h0, 0, LW, acc);
    wait_rsp(1);
    check("lw_be_addr", b_addr, 15'h0010);
    check("lw_be_nbytes", b_nb, 4);
    check("lw_be_wr", b_wr, 0);
    check("lw_be_fn3", b_fn3, LW);
    get_rsp("lw", 32'h1234_5678, 0, acc, 7);
    repeat (4) @(negedge mem_clk);
    check("lw_single_pulse", rsp_cnt, 1);

    lat = 1; rsp_q.push_back(32'hFFFF_FFFF);
    send(32'h8000_2003, 32'hAABB_CCDD, 1, SB, acc);
    wait_rsp(2);
    check("sb_be_wr", b_wr, 1);
    check("sb_be_nbytes", b_nb, 1);
    check("sb_be_wdata", b_wdata, 32'hAABB_CCDD);
    check("sb_be_addr", b_addr, 15'h0003);
    get_rsp("sb", 32'h0, 0, acc, 4);

    bv = bv_cycles;
    send(32'h8000_9FFE, 32'h0, 0, LW, acc);
    wait_rsp(3);
    get_rsp("oor_hi", 32'h0, 1, acc, 0);
    send(32'h8000_1FFC, 32'h0, 0, LW, acc);
    wait_rsp(4);
    get_rsp("oor_wrap", 32'h0, 1, acc, 0);
    send(32'h8000_2000, 32'h0, 0, 3'b011, acc);
    wait_rsp(5);
    get_rsp("ld_fn3_bad", 32'h0, 1, acc, 0);
    send(32'h8000_2000, 32'h5, 1, 3'b100, acc);
    wait_rsp(6);
    get_rsp("st_fn3_bad", 32'h0, 1, acc, 0);
    check("err_no_be_valid", bv_cycles, bv);

    lat = 2; rsp_q.push_back(32'hCAFE_F00D);
    send(32'h8000_9FFC, 32'h0, 0, LW, acc);
    wait_rsp(7);
    check("edge_be_addr", b_addr, 15'h7FFC);
    get_rsp("edge", 32'hCAFE_F00D, 0, acc, 5);

    be_req_ready = 0; lat = 1;
    rsp_q.push_back(32'h0000_00A1); rsp_q.push_back(32'h0000_00B2); rsp_q.push_back(32'h0000_00C3);
    send(32'h8000_2100, 32'h0, 0, LW, a0);
    send(32'h8000_2104, 32'h0, 0, LH, a1);
    send(32'h8000_2108, 32'h0, 0, LBU, a2);
    check("bp_ready_low", cpu_req_ready, 0);
    check("bp_stall", cpu_stall, 1);
    check("bp_be_valid", be_req_valid, 1);
    check("bp_be_addr", be_addr, 15'h0100);
    check("bp_no_rsp", rsp_cnt, 7);
    @(posedge mem_clk);
    #1 be_req_ready = 1;
    @(negedge mem_clk);
    wait_rsp(10);
    get_rsp("bp0", 32'h0000_00A1, 0, a0, 0);
    get_rsp("bp1", 32'h0000_00B2, 0, a1, 0);
    get_rsp("bp2", 32'h0000_00C3, 0, a2, 0);

`ifdef DMEM_MISALIGN_TRAP_EN
    send(32'h8000_2001, 32'h0, 0, LH, acc);
    wait_rsp(11);
    get_rsp("mis", 32'h0, 1, acc, 0);
`else
    rsp_q.push_back(32'h0000_0055);
    send(32'h8000_2001, 32'h0, 0, LH, acc);
    wait_rsp(11);
    check("mis_be_addr", b_addr, 15'h0001);
    check("mis_be_nbytes", b_nb, 2);
    get_rsp("mis", 32'h0000_0055, 0, acc, 0);
`endif

    be_auto = 0;
    send(32'h8000_2020, 32'h0, 0, LW, acc);
    send(32'h8000_2024, 32'h0, 0, LW, acc);
    t = 0;
    while (!be_req_valid && t < 50) begin @(negedge mem_clk); t++; end
    check("rst_mid_issue", be_req_valid, 1);
    @(negedge mem_clk);
    resetn = 0;
    #2;
    check("rst_mid_ready", cpu_req_ready, 1);
    check("rst_mid_be_valid", be_req_valid, 0);
    check("rst_mid_stall", cpu_stall, 0);
    @(negedge mem_clk);
    resetn = 1;
    @(negedge mem_clk);
    bv = bv_cycles;
    late_req++;
    repeat (6) @(negedge mem_clk);
    check("rst_late_ignored", rsp_cnt, 11);
    check("rst_post_ready", cpu_req_ready, 1);
    check("rst_post_stall", cpu_stall, 0);
    check("rst_queue_dropped", bv_cycles, bv);

    be_auto = 1; lat = 3; rsp_q.push_back(32'h0BAD_F00D);
    send(32'h8000_2040, 32'h0, 0, LW, acc);
    wait_rsp(12);
    get_rsp("post_rst_lw", 32'h0BAD_F00D, 0, acc, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
